// File: rtl/sal_cmd_sched_if.sv
//------------------------------------------------------------------------------
// Module  : sal_cmd_sched_if
// Brief   : Bank-controller request/grant bundle and DDR2 command bus of the
//           rank-level command scheduler.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sal_cmd_sched_if #(
  parameter int NUM_BANKS = 8,
  parameter int RA_WIDTH  = 14,
  parameter int CA_WIDTH  = 10,
  parameter int TW        = 4
);
  localparam int BA_WIDTH = $clog2(NUM_BANKS);

  logic [NUM_BANKS-1:0]          act_req_i;
  logic [NUM_BANKS-1:0]          rd_req_i;
  logic [NUM_BANKS-1:0]          wr_req_i;
  logic [NUM_BANKS-1:0]          pre_req_i;
  logic [NUM_BANKS-1:0]          ref_req_i;
  logic [NUM_BANKS*RA_WIDTH-1:0] ra_i;
  logic [NUM_BANKS*CA_WIDTH-1:0] ca_i;
  logic [TW-1:0]                 t_rrd_i;
  logic [TW-1:0]                 t_ccd_i;
  logic [TW-1:0]                 t_wtr_i;
  logic [TW-1:0]                 t_rtw_i;
  logic [NUM_BANKS-1:0]          act_gnt_o;
  logic [NUM_BANKS-1:0]          rd_gnt_o;
  logic [NUM_BANKS-1:0]          wr_gnt_o;
  logic [NUM_BANKS-1:0]          pre_gnt_o;
  logic [NUM_BANKS-1:0]          ref_gnt_o;
  logic                          cs_n_o;
  logic                          ras_n_o;
  logic                          cas_n_o;
  logic                          we_n_o;
  logic [BA_WIDTH-1:0]           ba_o;
  logic [RA_WIDTH-1:0]           addr_o;

  modport master (
    output act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i, ra_i, ca_i,
    output t_rrd_i, t_ccd_i, t_wtr_i, t_rtw_i,
    input  act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o,
    input  cs_n_o, ras_n_o, cas_n_o, we_n_o, ba_o, addr_o
  );

  modport slave (
    input  act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i, ra_i, ca_i,
    input  t_rrd_i, t_ccd_i, t_wtr_i, t_rtw_i,
    output act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o,
    output cs_n_o, ras_n_o, cas_n_o, we_n_o, ba_o, addr_o
  );
endinterface

`default_nettype wire

// File: rtl/sal_cmd_sched.sv
//------------------------------------------------------------------------------
// Module  : sal_cmd_sched
// Brief   : Rank-level DDR2 command scheduler: one zero-latency grant per cycle
//           with inter-bank spacing and a registered command bus.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sal_cmd_sched #(
  parameter int NUM_BANKS = 8,
  parameter int RA_WIDTH  = 14,
  parameter int CA_WIDTH  = 10,
  parameter int TW        = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  sal_cmd_sched_if.slave    bus
);
  localparam int BA_WIDTH = $clog2(NUM_BANKS);

  localparam logic [2:0] c_CLS_NONE = 3'd0;
  localparam logic [2:0] c_CLS_REF  = 3'd1;
  localparam logic [2:0] c_CLS_RD   = 3'd2;
  localparam logic [2:0] c_CLS_WR   = 3'd3;
  localparam logic [2:0] c_CLS_PRE  = 3'd4;
  localparam logic [2:0] c_CLS_ACT  = 3'd5;

  logic [TW-1:0]        r_rrd_cnt, r_ccd_cnt, r_wtr_cnt, r_rtw_cnt;
  logic [BA_WIDTH-1:0]  r_rr;
  logic                 w_act_ok, w_rd_ok, w_wr_ok;
  logic [NUM_BANKS-1:0] w_col_vec, w_act_vec, w_vec, w_onehot;
  logic [2:0]           w_cls;
  logic [BA_WIDTH-1:0]  w_bank;
  logic [RA_WIDTH-1:0]  w_col_addr;

  // First set bit of v scanning upward from ptr, wrapping at NUM_BANKS.
  function automatic logic [BA_WIDTH-1:0] f_rr_pick(input logic [NUM_BANKS-1:0] v,
                                                    input logic [BA_WIDTH-1:0]  ptr);
    logic [BA_WIDTH-1:0] pick;
    logic [BA_WIDTH-1:0] idx;
    pick = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      idx = BA_WIDTH'((32'(ptr) + 32'(i)) % NUM_BANKS);
      if (v[idx]) pick = idx;
    end
    return pick;
  endfunction

  function automatic logic [TW-1:0] f_load(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  function automatic logic [TW-1:0] f_dec(input logic [TW-1:0] c);
    return (c == '0) ? '0 : c - TW'(1);
  endfunction

  assign w_act_ok  = (r_rrd_cnt == '0);
  assign w_rd_ok   = (r_ccd_cnt == '0) && (r_wtr_cnt == '0);
  assign w_wr_ok   = (r_ccd_cnt == '0) && (r_rtw_cnt == '0);
  assign w_col_vec = (bus.rd_req_i & {NUM_BANKS{w_rd_ok}}) | (bus.wr_req_i & {NUM_BANKS{w_wr_ok}});
  assign w_act_vec = bus.act_req_i & {NUM_BANKS{w_act_ok}};

  always_comb begin
    w_cls = c_CLS_NONE;
    w_vec = '0;
    if (rst_n) begin
      if (|bus.ref_req_i) begin
        w_cls = c_CLS_REF;
        w_vec = bus.ref_req_i;
      end else if (|w_col_vec) begin
        w_cls = c_CLS_RD;
        w_vec = w_col_vec;
      end else if (|bus.pre_req_i) begin
        w_cls = c_CLS_PRE;
        w_vec = bus.pre_req_i;
      end else if (|w_act_vec) begin
        w_cls = c_CLS_ACT;
        w_vec = w_act_vec;
      end
    end
    w_bank = f_rr_pick(w_vec, r_rr);
    // RD and WR share one arbitration; the picked bank's own request decides which.
    if (w_cls == c_CLS_RD && !bus.rd_req_i[w_bank]) w_cls = c_CLS_WR;
    w_onehot = (w_cls == c_CLS_NONE) ? '0 : ({{(NUM_BANKS-1){1'b0}}, 1'b1} << w_bank);
  end

  assign bus.ref_gnt_o = (w_cls == c_CLS_REF) ? w_onehot : '0;
  assign bus.rd_gnt_o  = (w_cls == c_CLS_RD)  ? w_onehot : '0;
  assign bus.wr_gnt_o  = (w_cls == c_CLS_WR)  ? w_onehot : '0;
  assign bus.pre_gnt_o = (w_cls == c_CLS_PRE) ? w_onehot : '0;
  assign bus.act_gnt_o = (w_cls == c_CLS_ACT) ? w_onehot : '0;

  always_comb begin
    w_col_addr = '0;
    w_col_addr[CA_WIDTH-1:0] = bus.ca_i[int'(w_bank)*CA_WIDTH +: CA_WIDTH];
    w_col_addr[10] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rrd_cnt   <= '0;
      r_ccd_cnt   <= '0;
      r_wtr_cnt   <= '0;
      r_rtw_cnt   <= '0;
      r_rr        <= '0;
      bus.cs_n_o  <= 1'b1;
      bus.ras_n_o <= 1'b1;
      bus.cas_n_o <= 1'b1;
      bus.we_n_o  <= 1'b1;
      bus.ba_o    <= '0;
      bus.addr_o  <= '0;
    end else begin
      r_rrd_cnt <= (w_cls == c_CLS_ACT) ? f_load(bus.t_rrd_i) : f_dec(r_rrd_cnt);
      r_ccd_cnt <= (w_cls == c_CLS_RD || w_cls == c_CLS_WR) ? f_load(bus.t_ccd_i) : f_dec(r_ccd_cnt);
      r_wtr_cnt <= (w_cls == c_CLS_WR) ? f_load(bus.t_wtr_i) : f_dec(r_wtr_cnt);
      r_rtw_cnt <= (w_cls == c_CLS_RD) ? f_load(bus.t_rtw_i) : f_dec(r_rtw_cnt);
      if (w_cls != c_CLS_NONE) begin
        r_rr     <= BA_WIDTH'((32'(w_bank) + 32'd1) % NUM_BANKS);
        bus.ba_o <= w_bank;
      end
      case (w_cls)
        c_CLS_ACT: begin
          {bus.cs_n_o, bus.ras_n_o, bus.cas_n_o, bus.we_n_o} <= 4'b0011;
          bus.addr_o <= bus.ra_i[int'(w_bank)*RA_WIDTH +: RA_WIDTH];
        end
        c_CLS_RD: begin
          {bus.cs_n_o, bus.ras_n_o, bus.cas_n_o, bus.we_n_o} <= 4'b0101;
          bus.addr_o <= w_col_addr;
        end
        c_CLS_WR: begin
          {bus.cs_n_o, bus.ras_n_o, bus.cas_n_o, bus.we_n_o} <= 4'b0100;
          bus.addr_o <= w_col_addr;
        end
        c_CLS_PRE: begin
          {bus.cs_n_o, bus.ras_n_o, bus.cas_n_o, bus.we_n_o} <= 4'b0010;
          bus.addr_o <= '0;
        end
        c_CLS_REF: begin
          {bus.cs_n_o, bus.ras_n_o, bus.cas_n_o, bus.we_n_o} <= 4'b0001;
          bus.addr_o <= '0;
        end
        default: {bus.cs_n_o, bus.ras_n_o, bus.cas_n_o, bus.we_n_o} <= 4'b1111;
      endcase
    end
  end
endmodule

`default_nettype wire
